// File: rtl/pipeline_pkg.sv
// Shared pipeline constants for the integer datapath stages.
package pipeline_pkg;

  localparam int          DATA_W    = 32;
  localparam int          REG_IDX_W = 5;
  localparam int          NUM_REGS  = 32;
  localparam logic [5:0]  ALUOP_NOP = 6'b000000;

endpackage

// File: rtl/regfile_2r1w.sv
// Register file: two combinational read ports with write-back bypass, one synchronous write port.
// R0 reads as zero and ignores writes; every entry clears on asynchronous reset.
module regfile_2r1w #(
  parameter int DATA_W   = pipeline_pkg::DATA_W,
  parameter int NUM_REGS = pipeline_pkg::NUM_REGS,
  parameter int IDX_W    = pipeline_pkg::REG_IDX_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IDX_W-1:0]  ra1,
  input  logic [IDX_W-1:0]  ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  input  logic              we,
  input  logic [IDX_W-1:0]  wa,
  input  logic [DATA_W-1:0] wd
);

  logic [DATA_W-1:0] mem [NUM_REGS];
  logic              wr_hit;

  assign wr_hit = we && (wa != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) mem[i] <= '0;
    end else if (wr_hit) begin
      mem[wa] <= wd;
    end
  end

  // Same-cycle write-back wins over the stored value so S2 never sees stale data.
  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (ra1 != '0) rd1 = (wr_hit && (wa == ra1)) ? wd : mem[ra1];
    if (ra2 != '0) rd2 = (wr_hit && (wa == ra2)) ? wd : mem[ra2];
  end

endmodule

// File: rtl/s2_operand_fetch.sv
// Operand fetch stage: reads RS1/RS2 (or Imm), registers operands and control to S3 with one cycle latency.
// Stall holds every output; Flush (priority over Stall) loads a bubble. Write-back is never blocked.
module s2_operand_fetch #(
  parameter int DATA_W   = pipeline_pkg::DATA_W,
  parameter int NUM_REGS = pipeline_pkg::NUM_REGS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [4:0]        RS1,
  input  logic [4:0]        RS2,
  input  logic [4:0]        WS,
  input  logic [31:0]       Imm,
  input  logic [5:0]        ALUOP,
  input  logic              WE,
  input  logic              DS,
  input  logic              WB_WE,
  input  logic [4:0]        WB_WS,
  input  logic [31:0]       WB_Data,
  input  logic              Stall,
  input  logic              Flush,
  output logic [DATA_W-1:0] OpA,
  output logic [DATA_W-1:0] OpB,
  output logic [5:0]        ALUOP_out,
  output logic [4:0]        WS_out,
  output logic              WE_out
);

  logic [DATA_W-1:0] rd1;
  logic [DATA_W-1:0] rd2;
  logic [DATA_W-1:0] opb_nxt;

  regfile_2r1w #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS),
    .IDX_W    (pipeline_pkg::REG_IDX_W)
  ) u_rf (
    .clk   (clk),
    .rst_n (rst_n),
    .ra1   (RS1),
    .ra2   (RS2),
    .rd1   (rd1),
    .rd2   (rd2),
    .we    (WB_WE),
    .wa    (WB_WS),
    .wd    (DATA_W'(WB_Data))
  );

  assign opb_nxt = DS ? DATA_W'(Imm) : rd2;

  // Held operands are deliberately not refreshed by write-back; the hazard unit handles that case.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      OpA       <= '0;
      OpB       <= '0;
      ALUOP_out <= pipeline_pkg::ALUOP_NOP;
      WS_out    <= '0;
      WE_out    <= 1'b0;
    end else if (Flush) begin
      OpA       <= '0;
      OpB       <= '0;
      ALUOP_out <= pipeline_pkg::ALUOP_NOP;
      WS_out    <= '0;
      WE_out    <= 1'b0;
    end else if (!Stall) begin
      OpA       <= rd1;
      OpB       <= opb_nxt;
      ALUOP_out <= ALUOP;
      WS_out    <= WS;
      WE_out    <= WE;
    end
  end

endmodule

// File: doc/s2_operand_fetch.md
S2_OPERAND_FETCH -- requirements
Module: s2_operand_fetch

Interface
REQ-001 SHALL have parameter DATA_W, default 32, datapath width.
REQ-002 SHALL have parameter NUM_REGS, default 32, register file depth (5-bit index).
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port RS1  input  5  source register 1 index from S1.
REQ-006 SHALL have port RS2  input  5  source register 2 index from S1.
REQ-007 SHALL have port WS  input  5  destination register index from S1.
REQ-008 SHALL have port Imm  input  32  zero-extended immediate from S1.
REQ-009 SHALL have port ALUOP  input  6  operation code from S1.
REQ-010 SHALL have port WE  input  1  destination write enable from S1.
REQ-011 SHALL have port DS  input  1  operand-B select from S1: 1 = Imm, 0 = register RS2.
REQ-012 SHALL have port WB_WE  input  1  write-back enable from last stage.
REQ-013 SHALL have port WB_WS  input  5  write-back register index.
REQ-014 SHALL have port WB_Data  input  32  write-back data.
REQ-015 SHALL have port Stall  input  1  hold all stage outputs.
REQ-016 SHALL have port Flush  input  1  replace next stage output with bubble.
REQ-017 SHALL have ports OpA, OpB  output  32 each  registered operands to S3.
REQ-018 SHALL have ports ALUOP_out (6), WS_out (5), WE_out (1)  output  registered control forwarded to S3.

Function
REQ-019 SHALL contain a NUM_REGS x DATA_W register file; two combinational read ports, one synchronous write port.
REQ-020 SHALL write WB_Data to entry WB_WS on rising edge when WB_WE = 1 and WB_WS != 0, regardless of Stall/Flush.
REQ-021 SHALL read register 0 as 0 always; writes to index 0 ignored.
REQ-022 SHALL bypass: if WB_WE = 1, WB_WS != 0 and WB_WS equals a read index in the same cycle, that read SHALL return WB_Data instead of stored value.
REQ-023 SHALL compute next OpA = read(RS1); next OpB = DS ? Imm : read(RS2).
REQ-024 SHALL register OpA, OpB, ALUOP_out <= ALUOP, WS_out <= WS, WE_out <= WE with exactly one cycle latency.
REQ-025 SHALL, when Stall = 1 and Flush = 0, hold all outputs unchanged.
REQ-026 SHALL, when Flush = 1, load bubble: OpA = 0, OpB = 0, ALUOP_out = 6'b000000, WS_out = 0, WE_out = 0.
REQ-027 SHALL give Flush priority over Stall when both asserted.
REQ-028 SHALL not refresh held operands during Stall even if write-back targets a held source; hazard unit owns that case.

Reset
REQ-029 SHALL, on rst_n = 0, immediately (asynchronously) clear OpA, OpB, ALUOP_out, WS_out, WE_out and every register file entry to 0.
REQ-030 SHALL ignore WB_WE while rst_n = 0; first write accepted on first rising edge after deassertion.
REQ-031 SHALL abandon any in-flight instruction on reset mid-operation; no output retains pre-reset value.

Structure
REQ-032 SHALL place DATA_W, REG_IDX_W = 5, NUM_REGS = 32, ALUOP_NOP = 6'b000000 in shared package pipeline_pkg.
REQ-033 SHALL implement the register file as sub-module regfile_2r1w (two read ports, one write port, bypass, R0 hardwire).
REQ-034 SHALL keep stage register, stall/flush muxing and DS operand select in s2_operand_fetch.

Verification
REQ-035 Reset: rst_n low mid-cycle with WE_out = 1 -> all outputs 0 before next edge; read of R5 after reset -> 0.
REQ-036 Write then read: WB write R3 = 32'hDEADBEEF; next cycle RS1 = 3, DS = 0, RS2 = 0 -> one cycle later OpA = 32'hDEADBEEF, OpB = 0.
REQ-037 Bypass: same cycle WB_WE = 1, WB_WS = 7, WB_Data = 32'h12345678 and RS2 = 7, DS = 0 -> next edge OpB = 32'h12345678.
REQ-038 Immediate/R0: DS = 1, Imm = 32'h0000ABCD, RS1 = 0, WB write R0 = 32'hFFFFFFFF -> OpA = 0, OpB = 32'h0000ABCD.
REQ-039 Stall/Flush: outputs hold ALUOP_out = 6'h21 over 3 Stall cycles; Stall = 1 and Flush = 1 together -> WE_out = 0, ALUOP_out = 0.
